// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shifts a
// byte (LSB first) plus odd parity on device-generated clock falling edges
// and checks the device ACK. Open-drain enables: 1 = pull pin low.
// Optional: define PS2_TX_FILTER_EN to add a FILTER_LEN-cycle stability
// filter on the synchronised ps2_clk level.
module ps2_host_tx #(
  parameter int unsigned CLK_FREQ_HZ      = 25000000,
  parameter int unsigned INHIBIT_US       = 120,
  parameter int unsigned RTS_CYCLES       = 25,
  parameter int unsigned START_TIMEOUT_US = 15000,
  parameter int unsigned BIT_TIMEOUT_US   = 2000,
  parameter int unsigned FILTER_LEN       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CYC_PER_US = CLK_FREQ_HZ / 1000000;
  localparam int unsigned INH        = CYC_PER_US * INHIBIT_US;
  localparam int unsigned TS         = CYC_PER_US * START_TIMEOUT_US;
  localparam int unsigned TB         = CYC_PER_US * BIT_TIMEOUT_US;
  localparam int unsigned MAX_A      = (INH > TS) ? INH : TS;
  localparam int unsigned MAX_B      = (MAX_A > TB) ? MAX_A : TB;
  localparam int unsigned MAX_CNT    = (MAX_B > RTS_CYCLES) ? MAX_B : RTS_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CNT + 1);
  localparam int unsigned IDX_W      = 4;

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INH - 1);
  localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TS_LAST  = CNT_W'(TS - 1);
  localparam logic [CNT_W-1:0] TB_LAST  = CNT_W'(TB - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    INHIBIT    = 3'd1,
    RTS        = 3'd2,
    WAIT_FIRST = 3'd3,
    XFER       = 3'd4,
    WAIT_IDLE  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             tx_ready_q, tx_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic [1:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       data_sync_q, data_sync_d;
  logic             clk_prev_q, clk_prev_d;
  logic             clk_s, data_s, clk_lvl, clk_fall, abort_c;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

`ifdef PS2_TX_FILTER_EN
  localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);

  logic             filt_q, filt_d;
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;

  // Filtered level follows clk_s only after FILTER_LEN consecutive differing samples
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    if (clk_s != filt_q) begin
      if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
        filt_d = clk_s;
      end else begin
        flt_cnt_d = flt_cnt_q + FLT_W'(1);
      end
    end
  end

  // Filter state; idle bus level is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q    <= 1'b1;
      flt_cnt_q <= '0;
    end else begin
      filt_q    <= filt_d;
      flt_cnt_q <= flt_cnt_d;
    end
  end

  assign clk_lvl = filt_q;
`else
  logic unused_filter_len;
  assign unused_filter_len = ^32'(FILTER_LEN);
  assign clk_lvl = clk_s;
`endif

  assign clk_fall = clk_prev_q & ~clk_lvl;

  // Two-flop synchronisers and previous clock level for edge detection
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
    data_sync_d = {data_sync_q[0], ps2_data_in};
    clk_prev_d  = clk_lvl;
  end

  // Input path registers; reset to idle-high so no edge is seen after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_ready_d = tx_ready_q;
    busy_d     = busy_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    abort_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          shift_d    = tx_data;
          parity_d   = ~^tx_data;
          clk_oe_d   = 1'b1;
          data_oe_d  = 1'b0;
          busy_d     = 1'b1;
          tx_ready_d = 1'b0;
          cnt_d      = '0;
          bit_idx_d  = '0;
          state_d    = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          cnt_d     = '0;
          state_d   = RTS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RTS: begin
        if (cnt_q == RTS_LAST) begin
          clk_oe_d = 1'b0;
          cnt_d    = '0;
          state_d  = WAIT_FIRST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_FIRST: begin
        if (clk_fall) begin
          data_oe_d = ~shift_q[0];
          bit_idx_d = IDX_W'(1);
          cnt_d     = '0;
          state_d   = XFER;
        end else if (cnt_q == TS_LAST) begin
          abort_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      XFER: begin
        if (clk_fall) begin
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q <= IDX_W'(7)) begin
            data_oe_d = ~shift_q[bit_idx_q[2:0]];
          end else if (bit_idx_q == IDX_W'(8)) begin
            data_oe_d = ~parity_q;
          end else if (bit_idx_q == IDX_W'(9)) begin
            data_oe_d = 1'b0;
          end else if (!data_s) begin
            state_d = WAIT_IDLE;
          end else begin
            abort_c = 1'b1;
          end
        end else if (cnt_q == TB_LAST) begin
          abort_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        if (clk_lvl && data_s) begin
          done_d     = 1'b1;
          busy_d     = 1'b0;
          tx_ready_d = 1'b1;
          cnt_d      = '0;
          bit_idx_d  = '0;
          state_d    = IDLE;
        end else if (cnt_q == TB_LAST) begin
          abort_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort_c) begin
      clk_oe_d   = 1'b0;
      data_oe_d  = 1'b0;
      error_d    = 1'b1;
      busy_d     = 1'b0;
      tx_ready_d = 1'b1;
      cnt_d      = '0;
      bit_idx_d  = '0;
      state_d    = IDLE;
    end
  end

  // State and output registers; reset releases both lines at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
    end
  end

  assign tx_ready    = tx_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: 1 MHz system clock, device model with 60-cycle
// PS/2 clock period sharing open-drain lines with the DUT.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       error;
  logic       dev_clk_low;
  logic       dev_data_low;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  // Open-drain bus: either side may pull a line low
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ(1000000),
    .INHIBIT_US(120),
    .RTS_CYCLES(25),
    .START_TIMEOUT_US(500),
    .BIT_TIMEOUT_US(100),
    .FILTER_LEN(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .done(done),
    .error(error)
  );

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (done && error) both_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input string what,
                       input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s_%s: got %0h want %0h", tag, what, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic [9:0] exp_bits;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[5];

  // Full frame: accept, inhibit/RTS timing, 11 device clocks, result checks
  task automatic run_frame(input logic [7:0] data, input logic ack, input logic glitch,
                           input logic [9:0] exp_bits, input int exp_done,
                           input int exp_err, input string tag);
    int n;
    int d0;
    int e0;
    logic [9:0] got;
    got = '0;
    @(negedge clk);
    tx_data  = data;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    check(tag, "accept", 32'({tx_ready, busy, ps2_clk_oe, ps2_data_oe}), 32'h6);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check(tag, "inhibit", 32'(n), 32'd120);
    n = 0;
    while (ps2_clk_oe && ps2_data_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check(tag, "rts", 32'(n), 32'd25);
    check(tag, "start_bit", 32'(ps2_data_oe), 32'd1);
    d0 = done_cnt;
    e0 = err_cnt;
    repeat (20) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      if (k == 3) begin
        tx_valid = 1'b1;
        tx_data  = ~data;
      end
      if (k == 6) tx_valid = 1'b0;
      repeat (30) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) got[k-1] = ps2_data_in;
      if (k == 11) dev_data_low = 1'b0;
      if (glitch && k >= 2 && k <= 9) begin
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (2) @(negedge clk);
      end else begin
        repeat (15) @(negedge clk);
      end
      if (k == 10 && ack) dev_data_low = 1'b1;
      repeat (15) @(negedge clk);
    end
    tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    check(tag, "bits", 32'(got), 32'(exp_bits));
    check(tag, "done_pulses", 32'(done_cnt - d0), 32'(exp_done));
    check(tag, "err_pulses", 32'(err_cnt - e0), 32'(exp_err));
    check(tag, "end_state", 32'({tx_ready, busy, ps2_clk_oe, ps2_data_oe}), 32'h8);
  endtask

  initial begin
    int n;
    int e0;
    int d0;
    reset        = 1'b1;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", "during", 32'({tx_ready, busy, done, error, ps2_clk_oe, ps2_data_oe}), 32'h20);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", "after", 32'({tx_ready, busy, done, error, ps2_clk_oe, ps2_data_oe}), 32'h20);

    // data, ack, sampled bits {stop, parity, D7..D0}, done, error
    vecs[0] = '{8'hED, 1'b1, 10'h3ED, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 10'h300, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 10'h3FF, 1, 0};
    vecs[3] = '{8'h01, 1'b1, 10'h201, 1, 0};
    vecs[4] = '{8'hA5, 1'b0, 10'h3A5, 0, 1};
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].data, vecs[i].ack, 1'b0, vecs[i].exp_bits,
                vecs[i].exp_done, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Start timeout: device never clocks
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    tx_data  = 8'h12;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    n = 0;
    while (!error && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("tmo", "cycles", 32'(n), 32'd500);
    check("tmo", "lines", 32'({busy, ps2_clk_oe, ps2_data_oe}), 32'h0);
    repeat (5) @(negedge clk);
    check("tmo", "err_pulses", 32'(err_cnt - e0), 32'd1);
    check("tmo", "done_pulses", 32'(done_cnt - d0), 32'd0);
    check("tmo", "ready", 32'(tx_ready), 32'd1);

    // Reset after edge #4 of 0x52 (D3 = 0, so data is being pulled low)
    e0 = err_cnt;
    @(negedge clk);
    tx_data  = 8'h52;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      dev_clk_low = 1'b1;
      repeat (k == 4 ? 10 : 30) @(negedge clk);
      if (k < 4) begin
        dev_clk_low = 1'b0;
        repeat (30) @(negedge clk);
      end
    end
    check("rst", "pre_data_oe", 32'(ps2_data_oe), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst", "async_release", 32'({ps2_clk_oe, ps2_data_oe}), 32'h0);
    dev_clk_low = 1'b0;
    repeat (2) @(negedge clk);
    check("rst", "no_error", 32'(error), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst", "ready", 32'({tx_ready, busy}), 32'h2);
    repeat (3) @(negedge clk);
    check("rst", "err_pulses", 32'(err_cnt - e0), 32'd0);
    run_frame(8'hFF, 1'b1, 1'b0, 10'h3FF, 1, 0, "post_rst");

`ifdef PS2_TX_FILTER_EN
    run_frame(8'hED, 1'b1, 1'b1, 10'h3ED, 1, 0, "filt");
`endif

    check("all", "done_and_error_same_cycle", 32'(both_cnt), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
